// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, with a programmable repeat
// count and an idle gap between repetitions, using a start/busy/done handshake.
module seq_pattern_tx #(
    parameter int             LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b11011,
    parameter int             CNT_W   = 4
) (
    input  logic             clk_pulse,
    input  logic             clear_n,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_len,
    input  logic             hold,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       present_state
);

    localparam int             IDX_W    = $clog2(LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_rep_left;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_gap_len;

    always_ff @(posedge clk_pulse or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= IDLE;
            r_bit_idx  <= '0;
            r_rep_left <= '0;
            r_gap_cnt  <= '0;
            r_gap_len  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= SEND;
                        r_bit_idx  <= LAST_IDX;
                        r_rep_left <= repeat_cnt;
                        r_gap_len  <= gap_len;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (!hold) begin
                        if (r_bit_idx != '0) begin
                            r_bit_idx <= r_bit_idx - IDX_W'(1);
                        end else if (r_rep_left == '0) begin
                            r_state <= DONE;
                        end else if (r_gap_len == '0) begin
                            // back-to-back repetition, no bubble cycle
                            r_bit_idx  <= LAST_IDX;
                            r_rep_left <= r_rep_left - CNT_W'(1);
                        end else begin
                            r_state    <= GAP;
                            r_gap_cnt  <= r_gap_len - CNT_W'(1);
                            r_rep_left <= r_rep_left - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (!hold) begin
                        if (r_gap_cnt != '0) begin
                            r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                        end else begin
                            r_state   <= SEND;
                            r_bit_idx <= LAST_IDX;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore decode straight off the state registers so a reset clears outputs at once
    logic w_send;
    assign w_send        = (r_state == SEND);
    assign out_valid     = w_send;
    assign out_bit       = w_send & PATTERN[r_bit_idx];
    assign busy          = w_send | (r_state == GAP);
    assign done          = (r_state == DONE);
    assign present_state = r_state;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter. Emits a fixed bit pattern, MSB first, one bit per clk_pulse cycle.
- Supports a programmable repeat count and a programmable idle gap between repetitions.
- It is the stimulus/transmit end for the lab's serial sequence detectors. out_bit connects directly to a detector's serial input, and both blocks share clk_pulse.
- A start/busy/done handshake lets a controller or switch-driven top level launch bursts.

Parameters:
- LEN, 5, pattern length in bits (2..16).
- PATTERN, 5'b11011, pattern transmitted MSB (bit LEN-1) first.
- CNT_W, 4, width of repeat_cnt and gap_len.

Ports:
- clk_pulse  input  1  system clock; all state updates on the rising edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- repeat_cnt  input  CNT_W  number of repetitions minus 1 (0 means one pattern). Latched on start.
- gap_len  input  CNT_W  idle cycles inserted between repetitions (0 means back-to-back). Latched on start.
- hold  input  1  freezes transmission while high (SEND/GAP only).
- abort  input  1  synchronous abort to IDLE; no done pulse.
- out_bit  output  1  serial data.
- out_valid  output  1  high while out_bit carries a pattern bit.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse after the final bit.
- present_state  output  2  state code for LEDs/debug.

Behaviour:
- State register encoding: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11.
- Internal registers:
  - bit_idx, $clog2(LEN) bits.
  - rep_left, CNT_W bits.
  - gap_cnt, CNT_W bits.
  - gap_len latch, CNT_W bits.
- Reset (clear_n=0, asynchronous, any time including mid-burst): state=IDLE and all internal registers 0.
- Outputs are Moore-decoded from the registered state, so reset forces out_bit=0, out_valid=0, busy=0, done=0, present_state=00 immediately.
- Output decode:
  - SEND: out_bit=PATTERN[bit_idx], out_valid=1, busy=1.
  - GAP: out_bit=0, out_valid=0, busy=1.
  - DONE: done=1, busy=0, out_bit=0, out_valid=0.
  - IDLE: all outputs 0.
- IDLE:
  - start=1 at an edge → SEND, bit_idx=LEN-1, rep_left=repeat_cnt, gap_len latched.
  - The first bit is therefore visible in the cycle after start is sampled (latency 1).
  - start=0 → stay in IDLE.
- SEND, with hold=0 and abort=0:
  - bit_idx>0 → bit_idx decrements.
  - bit_idx==0 and rep_left==0 → DONE.
  - bit_idx==0, rep_left>0, latched gap==0 → stay in SEND, bit_idx=LEN-1, rep_left decrements. Back-to-back with no bubble.
  - bit_idx==0, rep_left>0, latched gap>0 → GAP, gap_cnt=gap-1, rep_left decrements.
- GAP, with hold=0 and abort=0:
  - gap_cnt>0 → gap_cnt decrements.
  - gap_cnt==0 → SEND, bit_idx=LEN-1.
  - GAP therefore lasts exactly gap_len cycles.
- DONE: unconditionally → IDLE after one cycle. start during DONE is ignored; start is honoured again from the following IDLE cycle.
- hold=1 in SEND/GAP: all registers frozen, and outputs stay at their current decoded values. In SEND this means out_bit is held, which the detector will re-sample; this is intended for use with a gated clock only. hold is ignored in IDLE and DONE.
- abort=1 in SEND/GAP → IDLE at the next edge, no done pulse. abort has priority over hold. abort is ignored in IDLE and DONE.
- start while busy: ignored. Latched repeat_cnt/gap_len are unaffected by input changes during a burst.
- Total cycles from the start edge to the done pulse (no hold): (repeat_cnt+1)·LEN + repeat_cnt·gap_len.
- Maximum burst: repeat_cnt=2^CNT_W−1. There is no wrap of rep_left; the count terminates at 0.

Test Plan:
- Single burst: reset, then start pulse with repeat_cnt=0, gap_len=0 → out_valid high 5 cycles with out_bit 1,1,0,1,1. done high in cycle 6, then IDLE; busy low from cycle 6.
- Back-to-back loopback: repeat_cnt=1, gap_len=0, out_bit driven into the 11011 detector → 10 valid cycles with stream 1101111011. Detector out asserts once per pattern, 2 times total. done after cycle 10.
- Gap: repeat_cnt=2, gap_len=3 → pattern, 3 cycles out_valid=0/out_bit=0, pattern, 3 idle, pattern. done at cycle 22 (3·5+2·3+1); busy high for cycles 1–21.
- Hold/abort: hold=1 for 4 cycles during bit index 2 → the same bit is presented for 5 cycles, then the sequence resumes unchanged. abort=1 asserted together with hold=1 → IDLE next edge, no done pulse.
- Reset mid-operation: clear_n low during the GAP state, between clock edges → outputs 0 and present_state=00 immediately. After release, a new start gives a clean burst. start asserted while busy has no effect on length.
